// File: rtl/sram_burst_controller.sv
// sram_burst_controller
// Bridges the MEM stage to an asynchronous external SRAM. One WORD_WIDTH access
// becomes BEATS = WORD_WIDTH/SRAM_DQ_WIDTH sequential SRAM beats. Each beat lasts
// WAIT_CYCLES+1 clocks, and beat 0 carries the most-significant slice.
// ready is low while a request is pending or in flight, which stalls the pipeline.
// Optional feature macro: SRAM_BYTE_MASK_EN. It enables per-byte write masking
// through SRAM_UB_N/SRAM_LB_N and requires SRAM_DQ_WIDTH == 16.
module sram_burst_controller #(
  parameter int WORD_WIDTH      = 32,
  parameter int SRAM_DQ_WIDTH   = 16,
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int WAIT_CYCLES     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_en,
  input  logic                       wr_en,
  input  logic [31:0]                address,
  input  logic [WORD_WIDTH-1:0]      wr_data,
  input  logic [WORD_WIDTH/8-1:0]    byte_en,
  output logic [WORD_WIDTH-1:0]      rd_data,
  output logic                       ready,
  inout  wire  [SRAM_DQ_WIDTH-1:0]   SRAM_DQ,
  output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic                       SRAM_UB_N,
  output logic                       SRAM_LB_N,
  output logic                       SRAM_WE_N,
  output logic                       SRAM_CE_N,
  output logic                       SRAM_OE_N
);

  localparam int BEATS      = WORD_WIDTH / SRAM_DQ_WIDTH;
  localparam int LOG2_BEATS = $clog2(BEATS);
  localparam int BEAT_W     = (LOG2_BEATS > 0) ? LOG2_BEATS : 1;
  localparam int CYC_W      = $clog2(WAIT_CYCLES + 1);
  localparam int HI_W       = SRAM_ADDR_WIDTH - LOG2_BEATS;
  localparam int ADDR_MSB   = HI_W + 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic [CYC_W-1:0]           cyc_q, cyc_d;
  logic [HI_W-1:0]            addr_hi_q, addr_hi_d;
  logic [WORD_WIDTH-1:0]      wdata_q, wdata_d;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic [WORD_WIDTH-1:0]      rd_data_q, rd_data_d;

  logic                       req;
  logic                       last_cyc;
  logic                       last_beat;
  logic                       dq_oe;
  logic [SRAM_DQ_WIDTH-1:0]   dq_out;
  logic [SRAM_DQ_WIDTH-1:0]   wr_slice [BEATS];

  // Only the word-address bits of the byte address reach the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:ADDR_MSB+1], address[1:0]};

  assign req       = rd_en | wr_en;
  assign last_cyc  = (cyc_q == LAST_CYC);
  assign last_beat = (beat_q == LAST_BEAT);

  // Full SRAM word address: the word's base address with the beat number appended.
  function automatic logic [SRAM_ADDR_WIDTH-1:0] word_addr(
    input logic [HI_W-1:0]   hi,
    input logic [BEAT_W-1:0] beat
  );
    word_addr = (SRAM_ADDR_WIDTH'(hi) << LOG2_BEATS) | SRAM_ADDR_WIDTH'(beat);
  endfunction

  // Per-beat slices of the latched write word. Beat 0 is the top slice.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_wr_slice
    assign wr_slice[gi] = wdata_q[WORD_WIDTH-1-gi*SRAM_DQ_WIDTH -: SRAM_DQ_WIDTH];
  end

`ifdef SRAM_BYTE_MASK_EN
  localparam int BYTES = WORD_WIDTH / 8;

  logic [BYTES-1:0] be_q, be_d;
  logic             ub_en [BEATS];
  logic             lb_en [BEATS];

  // Byte enables covering each beat's upper and lower byte lanes.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_byte_lane
    assign ub_en[gi] = be_q[BYTES-1-2*gi];
    assign lb_en[gi] = be_q[BYTES-2-2*gi];
  end

  // Latch the byte mask with the write so a dropped request still completes intact.
  always_comb begin
    be_d = be_q;
    if (state_q == ST_IDLE && wr_en && !rd_en) begin
      be_d = byte_en;
    end
  end

  // Byte-mask register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      be_q <= '0;
    end else begin
      be_q <= be_d;
    end
  end
`else
  // Without byte masking every write stores the whole slice.
  logic unused_byte_en;
  assign unused_byte_en = ^byte_en;
`endif

  // Next state: accept in IDLE, step cyc/beat, capture read slices, one DONE cycle.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    cyc_d       = cyc_q;
    addr_hi_d   = addr_hi_q;
    wdata_d     = wdata_q;
    sram_addr_d = sram_addr_q;
    rd_data_d   = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          // A simultaneous read and write takes the read first.
          state_d     = rd_en ? ST_READ : ST_WRITE;
          beat_d      = '0;
          cyc_d       = '0;
          addr_hi_d   = address[ADDR_MSB:2];
          sram_addr_d = word_addr(address[ADDR_MSB:2], '0);
          if (!rd_en) begin
            wdata_d = wr_data;
          end
        end
      end
      ST_READ, ST_WRITE: begin
        if (last_cyc) begin
          if (state_q == ST_READ) begin
            for (int i = 0; i < BEATS; i++) begin
              if (beat_q == BEAT_W'(i)) begin
                rd_data_d[WORD_WIDTH-1-i*SRAM_DQ_WIDTH -: SRAM_DQ_WIDTH] = SRAM_DQ;
              end
            end
          end
          if (last_beat) begin
            state_d = ST_DONE;
          end else begin
            beat_d      = beat_q + BEAT_W'(1);
            cyc_d       = '0;
            sram_addr_d = word_addr(addr_hi_q, beat_q + BEAT_W'(1));
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      cyc_q       <= '0;
      addr_hi_q   <= '0;
      wdata_q     <= '0;
      sram_addr_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      cyc_q       <= cyc_d;
      addr_hi_q   <= addr_hi_d;
      wdata_q     <= wdata_d;
      sram_addr_q <= sram_addr_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Strobe decode from registered state.
  // On writes, WE_N rises on the last cycle of each beat to give data hold.
  always_comb begin
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = wr_slice[beat_q];
    case (state_q)
      ST_READ: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
      end
      ST_WRITE: begin
        SRAM_CE_N = 1'b0;
        dq_oe     = 1'b1;
`ifdef SRAM_BYTE_MASK_EN
        SRAM_UB_N = ~ub_en[beat_q];
        SRAM_LB_N = ~lb_en[beat_q];
        // A fully masked beat still spends its cycles but never strobes WE_N.
        SRAM_WE_N = last_cyc | ~(ub_en[beat_q] | lb_en[beat_q]);
`else
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        SRAM_WE_N = last_cyc;
`endif
      end
      default: begin
      end
    endcase
  end

  assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DQ_WIDTH{1'bz}};
  assign SRAM_ADDR = sram_addr_q;
  assign rd_data   = rd_data_q;
  assign ready     = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);

endmodule

// File: tb/tb_sram_burst_controller.sv
// Testbench for sram_burst_controller (default 32/16/18 geometry).
// A second instance with WAIT_CYCLES=4 checks the beat-timing scaling.
module tb_sram_burst_controller;

  localparam int WW  = 32;
  localparam int DQW = 16;
  localparam int AW  = 18;
  localparam int WC  = 2;
  localparam int B   = WW / DQW;
  localparam int L   = B * (WC + 1);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, wr_data = '0;
  logic [3:0]  byte_en = '0;
  logic [31:0] rd_data;
  logic        ready;
  tri1  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;

  logic        rd4 = 1'b0, wr4 = 1'b0;
  logic [31:0] rd_data4;
  logic        ready4;
  tri1  [15:0] dq4;
  logic [17:0] addr4;
  logic        ub4, lb4, we4, ce4, oe4;

  int checks = 0;
  int errors = 0;
  int we_low_cnt = 0;

  always #5 clk = ~clk;

  sram_burst_controller #(.WORD_WIDTH(WW), .SRAM_DQ_WIDTH(DQW), .SRAM_ADDR_WIDTH(AW),
                          .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .wr_data(wr_data), .byte_en(byte_en), .rd_data(rd_data), .ready(ready),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n));

  sram_burst_controller #(.WORD_WIDTH(WW), .SRAM_DQ_WIDTH(DQW), .SRAM_ADDR_WIDTH(AW),
                          .WAIT_CYCLES(4)) u_dut4 (
    .clk(clk), .rst(rst), .rd_en(rd4), .wr_en(wr4), .address(address),
    .wr_data(wr_data), .byte_en(byte_en), .rd_data(rd_data4), .ready(ready4),
    .SRAM_DQ(dq4), .SRAM_ADDR(addr4), .SRAM_UB_N(ub4), .SRAM_LB_N(lb4),
    .SRAM_WE_N(we4), .SRAM_CE_N(ce4), .SRAM_OE_N(oe4));

  // ---------------- external SRAM device ----------------
  logic [15:0] dev_mem [0:(1<<AW)-1];
  logic [15:0] ref_mem [0:(1<<AW)-1];

  assign SRAM_DQ = (!ce_n && !oe_n && we_n) ? dev_mem[SRAM_ADDR] : 16'bz;

  initial begin
    forever begin
      @(negedge clk);
      if (!ce_n && !we_n) begin
        we_low_cnt = we_low_cnt + 1;
        if (!ub_n) dev_mem[SRAM_ADDR][15:8] = SRAM_DQ[15:8];
        if (!lb_n) dev_mem[SRAM_ADDR][7:0]  = SRAM_DQ[7:0];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // k = clocks since acceptance (-1 idle). Clocks 0..L-1 are beats of WC+1
  // clocks each, and clock L is the single ready cycle.
  int          k = -1;
  bit          m_rd;
  logic [16:0] m_base;
  logic [31:0] m_wd;
  logic [3:0]  m_be;
  logic [31:0] exp_rd = '0;
  logic [17:0] exp_addr = '0;

  task automatic model_write();
    for (int b = 0; b < B; b++) begin
      logic [15:0] sl;
      logic        hb, lb;
      logic [17:0] wa;
      sl = (b == 0) ? m_wd[31:16] : m_wd[15:0];
      hb = (b == 0) ? m_be[3] : m_be[1];
      lb = (b == 0) ? m_be[2] : m_be[0];
      wa = {m_base, b[0]};
`ifndef SRAM_BYTE_MASK_EN
      hb = 1'b1;
      lb = 1'b1;
`endif
      if (hb) ref_mem[wa][15:8] = sl[15:8];
      if (lb) ref_mem[wa][7:0]  = sl[7:0];
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        k = -1;
        exp_rd = '0;
        exp_addr = '0;
      end else if (k == -1) begin
        if (rd_en || wr_en) begin
          m_rd = rd_en;
          m_base = address[18:2];
          m_wd = wr_data;
          m_be = byte_en;
          exp_addr = {m_base, 1'b0};
          k = 0;
          if (!m_rd) model_write();
        end
      end else begin
        if (k < L && m_rd && (k % (WC + 1)) == WC) begin
          if (k / (WC + 1) == 0) exp_rd[31:16] = ref_mem[{m_base, 1'b0}];
          else                   exp_rd[15:0]  = ref_mem[{m_base, 1'b1}];
        end
        if (k == L) begin
          k = -1;
        end else begin
          k = k + 1;
          if (k < L) exp_addr = {m_base, 1'b0} + 18'(k / (WC + 1));
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      int   b, c;
      logic hb, lb, ubx, lbx, en;
      @(negedge clk);
      if (!rst) begin
        chk("rd_data", rd_data, exp_rd);
        chk("sram_addr", SRAM_ADDR, exp_addr);
        if (k == -1 || k == L) begin
          chk("ready_idle_done", ready, (k == L) ? 1'b1 : !(rd_en || wr_en));
          chk("strobes_idle", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
          chk("dq_idle_undriven", SRAM_DQ, 16'hFFFF);
        end else begin
          b = k / (WC + 1);
          c = k % (WC + 1);
          chk("ready_busy", ready, 1'b0);
          if (m_rd) begin
            chk("strobes_rd", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b00100);
            chk("dq_rd", SRAM_DQ, dev_mem[exp_addr]);
          end else begin
            hb = (b == 0) ? m_be[3] : m_be[1];
            lb = (b == 0) ? m_be[2] : m_be[0];
`ifdef SRAM_BYTE_MASK_EN
            ubx = ~hb; lbx = ~lb; en = hb | lb;
`else
            ubx = 1'b0; lbx = 1'b0; en = 1'b1;
`endif
            chk("strobes_wr", {ce_n, oe_n, we_n, ub_n, lb_n},
                {1'b0, 1'b1, !(en && c < WC), ubx, lbx});
            chk("dq_wr", SRAM_DQ, (b == 0) ? m_wd[31:16] : m_wd[15:0]);
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // Wait for ready, counting edges from the accepting edge to the edge that sees ready.
  task automatic wait_ready(input bit drop, output int lat);
    int n;
    n = 0;
    lat = -1;
    while (n < 200) begin
      @(negedge clk);
      if (ready) begin
        lat = n + 1;
        break;
      end
      if (drop && n == 0) begin
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        address = $urandom;
        wr_data = $urandom;
        byte_en = 4'($urandom);
      end
      n = n + 1;
    end
    if (lat < 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL ready_timeout got=none want=ready within 200 cycles");
    end
  endtask

  task automatic do_req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit hold_wr, input bit drop, output int lat);
    @(negedge clk);
    #1;
    rd_en = r; wr_en = w; address = a; wr_data = d; byte_en = be;
    wait_ready(drop, lat);
    #1;
    rd_en = 1'b0;
    if (!hold_wr) wr_en = 1'b0;
    $display("txn rd=%0b wr=%0b addr=%h wdata=%h be=%h lat=%0d rd_data=%h",
             r, w, a, d, be, lat, rd_data);
  endtask

  initial begin
    int lat, lat2, n, b0_len, b0_we, b1_len, b1_we;
    logic r, w;
    logic [31:0] a;
    for (int i = 0; i < (1 << AW); i++) begin
      dev_mem[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_sram_addr", SRAM_ADDR, 18'h0);
    chk("rst_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
    chk("rst_dq_undriven", SRAM_DQ, 16'hFFFF);
    chk("rst_ready", ready, 1'b1);
    #1 rst = 1'b0;

    // Write 0xDEADBEEF to 0x10.
    we_low_cnt = 0;
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, lat);
    chk("wr_latency", lat, 7);
    chk("wr_sram8", dev_mem[8], 16'hDEAD);
    chk("wr_sram9", dev_mem[9], 16'hBEEF);
    chk("wr_we_low_cycles", we_low_cnt, 4);

    // Read it back.
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, lat);
    chk("rd_latency", lat, 7);
    chk("rd_word", rd_data, 32'hDEADBEEF);

    // Simultaneous read and write: read first, then the held write.
    do_req(1'b1, 1'b1, 32'h10, 32'h12345678, 4'hF, 1'b1, 1'b0, lat);
    chk("both_rd_first", rd_data, 32'hDEADBEEF);
    chk("both_rd_latency", lat, 7);
    wait_ready(1'b0, lat2);
    #1 wr_en = 1'b0;
    chk("both_wr_latency_from_done", lat2, 8);
    chk("both_sram8", dev_mem[8], 16'h1234);
    chk("both_sram9", dev_mem[9], 16'h5678);

    // WAIT_CYCLES=4 instance: 11-edge latency, 5-cycle beats, WE_N low 4 per beat.
    @(negedge clk);
    #1 address = 32'h10; wr_data = 32'hA1B2C3D4; byte_en = 4'hF; wr4 = 1'b1;
    n = 0; lat = -1; b0_len = 0; b0_we = 0; b1_len = 0; b1_we = 0;
    while (n < 200) begin
      @(negedge clk);
      if (ready4) begin
        lat = n + 1;
        break;
      end
      if (!ce4 && addr4 == 18'd8) begin b0_len++; if (!we4) b0_we++; end
      if (!ce4 && addr4 == 18'd9) begin b1_len++; if (!we4) b1_we++; end
      n = n + 1;
    end
    #1 wr4 = 1'b0;
    chk("w4_latency", lat, 11);
    chk("w4_beat0_len", b0_len, 5);
    chk("w4_beat0_we_low", b0_we, 4);
    chk("w4_beat1_len", b1_len, 5);
    chk("w4_beat1_we_low", b1_we, 4);
    $display("txn w4 lat=%0d beat0=%0d/%0d beat1=%0d/%0d", lat, b0_len, b0_we, b1_len, b1_we);

`ifdef SRAM_BYTE_MASK_EN
    // Masked write over 0xDEADBEEF: only byte 2 changes.
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, lat);
    we_low_cnt = 0;
    do_req(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0100, 1'b0, 1'b0, lat);
    chk("mask_we_low_cycles", we_low_cnt, 2);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, lat);
    chk("mask_readback", rd_data, 32'hDE22BEEF);
`endif

    // Randomized traffic, including requests dropped right after acceptance.
    for (int t = 0; t < 150; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r = 1'($urandom);
      w = 1'($urandom);
      if (!r && !w) w = 1'b1;
      a = $urandom;
      a[18:2] = 17'($urandom_range(0, 15));
      do_req(r, w, a, $urandom, 4'($urandom), 1'b0, ($urandom_range(0, 3) == 0), lat);
      chk("rand_latency", lat, 7);
    end

    // Reset during cycle 1 of write beat 1.
    @(negedge clk);
    #1 wr_en = 1'b1; address = 32'h10; wr_data = 32'hCAFEF00D; byte_en = 4'hF;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_we_n", we_n, 1'b1);
    chk("abort_ce_n", ce_n, 1'b1);
    chk("abort_dq_undriven", SRAM_DQ, 16'hFFFF);
    chk("abort_sram_addr", SRAM_ADDR, 18'h0);
    chk("abort_rd_data", rd_data, 32'h0);
    wr_en = 1'b0;
    #1;
    chk("abort_ready_no_req", ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    $display("txn reset-abort during write beat 1");
    // The aborted word's contents are undefined; adopt whatever the device holds.
    ref_mem[8] = dev_mem[8];
    ref_mem[9] = dev_mem[9];

    // Recovery after the abort.
    do_req(1'b0, 1'b1, 32'h10, 32'h0BADF00D, 4'hF, 1'b0, 1'b0, lat);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, lat);
    chk("recover_readback", rd_data, 32'h0BADF00D);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_burst_controller.md
Name: sram_burst_controller

Overview:
- Parametrised successor to the memory-stage SRAM controller.
- Splits one WORD_WIDTH access into BEATS = WORD_WIDTH/SRAM_DQ_WIDTH sequential SRAM beats, each with programmable wait cycles.
- Drives a true tri-state DQ bus and proper CE/OE/WE/byte-mask strobes.
- Sits between the MEM stage and the external SRAM; deasserted ready freezes the pipeline.

Parameters:
WORD_WIDTH, 32, processor word width; must be a multiple of SRAM_DQ_WIDTH.
SRAM_DQ_WIDTH, 16, SRAM data bus width.
SRAM_ADDR_WIDTH, 18, SRAM word-address width.
WAIT_CYCLES, 2, extra cycles per beat; minimum 1.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
rd_en  input  1  read request; held until ready
wr_en  input  1  write request; held until ready
address  input  32  byte address; bits [1:0] ignored
wr_data  input  WORD_WIDTH  write word
byte_en  input  WORD_WIDTH/8  write byte mask; used only with the optional feature
rd_data  output  WORD_WIDTH  last completed read word, registered
ready  output  1  low while a request is pending or in progress
SRAM_DQ  inout  SRAM_DQ_WIDTH  data bus
SRAM_ADDR  output  SRAM_ADDR_WIDTH  SRAM word address
SRAM_UB_N, SRAM_LB_N  output  1 each  byte masks, active low
SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  output  1 each  strobes, active low

Behaviour:
- States:
  - IDLE: a request seen at a clock edge moves to READ or WRITE, with beat=0 and cyc=0.
  - READ / WRITE: cyc counts 0..WAIT_CYCLES.
    - At cyc==WAIT_CYCLES, beat increments and cyc returns to 0.
    - After the last beat, go to DONE.
  - DONE: lasts one cycle; ready=1; then IDLE.
- ready:
  - Combinational: ready = (IDLE and no request) or DONE.
  - Access latency is BEATS*(WAIT_CYCLES+1)+1 edges from the accepting edge to ready high. Defaults: 7.
- Simultaneous rd_en and wr_en in IDLE: read wins; the write is taken after DONE if still asserted.
- SRAM_ADDR = {address[SRAM_ADDR_WIDTH-log2(BEATS)+1 : 2], beat}, valid for the whole beat.
- Beat order:
  - Beat 0 carries the most-significant slice: wr_data[WORD_WIDTH-1 -: SRAM_DQ_WIDTH].
  - The last beat carries bits [SRAM_DQ_WIDTH-1:0].
- WRITE:
  - DQ driven with the beat slice for the whole beat.
  - CE_N=0, OE_N=1.
  - WE_N=0 for cyc<WAIT_CYCLES and 1 at cyc==WAIT_CYCLES, giving data hold.
- READ:
  - DQ high-Z; CE_N=0, OE_N=0, WE_N=1.
  - The SRAM_DQ input is captured into the matching rd_data slice at cyc==WAIT_CYCLES.
  - rd_data changes only on read beats and holds between reads.
- IDLE/DONE: DQ high-Z, CE_N=OE_N=WE_N=UB_N=LB_N=1, SRAM_ADDR holds.
- Reset values:
  - State IDLE; beat and cyc 0.
  - rd_data=0, SRAM_ADDR=0.
  - DQ high-Z; all strobes 1.
  - ready=1 when no request is present.
- Reset mid-operation: aborts immediately and asynchronously. WE_N goes high in the same instant, so a partially written word is possible and accepted. No DONE pulse.
- A request dropped mid-access: the access still completes (no abort).

Optional Feature:
- Macro: SRAM_BYTE_MASK_EN. Requires SRAM_DQ_WIDTH=16.
- With the macro, on WRITE beats:
  - UB_N = ~byte_en of the slice's high byte; LB_N = ~byte_en of its low byte.
  - A beat with both bytes masked keeps WE_N=1 but still takes its cycles.
  - Reads drive UB_N=LB_N=0.
- Without the macro: byte_en is ignored, and UB_N=LB_N=0 whenever CE_N=0.

Test Plan:
- Write 0xDEADBEEF to address 0x10, defaults:
  - SRAM[8]=0xDEAD and SRAM[9]=0xBEEF.
  - WE_N low 2 cycles per beat.
  - ready high exactly 7 edges after acceptance, for 1 cycle.
- Read address 0x10 after the write: rd_data=0xDEADBEEF when ready rises; OE_N=0 and DQ undriven throughout.
- rd_en=wr_en=1, address 0x10, wr_data 0x12345678:
  - The read completes first with 0xDEADBEEF.
  - The write follows, and SRAM[8..9] = 0x1234, 0x5678.
- WAIT_CYCLES=4: ready rises 11 edges after acceptance; each beat lasts 5 cycles with WE_N low 4.
- Assert rst during cyc 1 of write beat 1:
  - WE_N=1 and DQ high-Z immediately.
  - ready never pulses; SRAM[9] is unchanged from its prior value or partially written, and is not checked.
- With SRAM_BYTE_MASK_EN, byte_en=4'b0100, wr_data 0x11223344 over 0xDEADBEEF:
  - Beat 0: UB_N=1, LB_N=0. Beat 1: WE_N stays 1.
  - Readback gives 0xDE22BEEF.
